// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and defaults for the pipeline skid register stage.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam int DATA_W_DEFAULT = 128;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with synchronous reset, clear and load enable.
module pipe_data_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)        q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage: a main entry plus an optional skid entry that
// lets in_ready come straight from a flop, with flush and a stall counter.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_e       state, state_next;
  logic              skid_valid;
  logic              in_xfer, out_xfer;
  logic              main_load, main_clr, main_from_skid, skid_load, skid_clr;
  logic [DATA_W-1:0] main_d, main_q, skid_q;

  assign out_valid  = (state != EMPTY);
  assign skid_valid = (state == TWO);
  assign occupancy  = 2'(out_valid) + 2'(skid_valid);
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid && out_ready;
  assign out_data   = main_q;
  assign main_d     = main_from_skid ? skid_q : in_data;

  // Payloads are cleared whenever their entry empties so out_data reads zero.
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      main_clr   = 1'b1;
      skid_clr   = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_next = ONE;
            main_load  = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer && (SKID != 0)) begin
            state_next = TWO;
            skid_load  = 1'b1;
          end else if (out_xfer) begin
            state_next = EMPTY;
            main_clr   = 1'b1;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_next     = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      // Registered ready: a skid slot is free unless the next state is TWO.
      always_ff @(posedge clk) begin
        if (rst) in_ready_q <= 1'b1;
        else     in_ready_q <= (state_next != TWO);
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  pipe_data_reg #(.W(DATA_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (main_clr),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_data_reg #(.W(DATA_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (skid_clr),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench: a SKID=1/CNT_W=2 stage and a SKID=0 stage on one clock.
module tb_pipe_skid_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic [7:0] a_in_data = 0;
  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_data;
  logic [1:0] a_occ;
  logic [1:0] a_stall;

  logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic [7:0]  b_in_data = 0;
  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_out_data;
  logic [1:0]  b_occ;
  logic [15:0] b_stall;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(8), .SKID(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_skid_reg #(.DATA_W(8), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit sel_b, input logic v, input logic [7:0] d,
                               input logic ordy, input logic fl);
    if (sel_b) begin
      b_in_valid = v; b_in_data = d; b_out_ready = ordy; b_flush = fl;
    end else begin
      a_in_valid = v; a_in_data = d; a_out_ready = ordy; a_flush = fl;
    end
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkA(input string tag, input logic v, input logic [7:0] d,
                        input logic [1:0] occ, input logic rdy);
    checkOutput({tag, ".out_valid"}, 32'(a_out_valid), 32'(v));
    checkOutput({tag, ".out_data"},  32'(a_out_data),  32'(d));
    checkOutput({tag, ".occupancy"}, 32'(a_occ),       32'(occ));
    checkOutput({tag, ".in_ready"},  32'(a_in_ready),  32'(rdy));
  endtask

  task automatic checkB(input string tag, input logic v, input logic [7:0] d,
                        input logic [1:0] occ, input logic rdy);
    checkOutput({tag, ".out_valid"}, 32'(b_out_valid), 32'(v));
    checkOutput({tag, ".out_data"},  32'(b_out_data),  32'(d));
    checkOutput({tag, ".occupancy"}, 32'(b_occ),       32'(occ));
    checkOutput({tag, ".in_ready"},  32'(b_in_ready),  32'(rdy));
  endtask

  initial begin
    // Reset both stages.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkA("a_reset", 0, 8'h00, 2'd0, 1);
    checkOutput("a_reset.stall", 32'(a_stall), 32'd0);
    checkB("b_reset", 0, 8'h00, 2'd0, 1);
    checkOutput("b_reset.stall", 32'(b_stall), 32'd0);

    // Streaming 1,2,3 with out_ready=1.
    applyStimulus(0, 1, 8'h01, 1, 0);
    tick(); checkA("stream1", 1, 8'h01, 2'd1, 1);
    applyStimulus(0, 1, 8'h02, 1, 0);
    tick(); checkA("stream2", 1, 8'h02, 2'd1, 1);
    applyStimulus(0, 1, 8'h03, 1, 0);
    tick(); checkA("stream3", 1, 8'h03, 2'd1, 1);
    applyStimulus(0, 0, 8'h00, 1, 0);
    tick(); checkA("stream_drain", 0, 8'h00, 2'd0, 1);

    // Back-pressure fills the skid entry, then drains in order.
    applyStimulus(0, 1, 8'h0A, 0, 0);
    tick(); checkA("bp_a", 1, 8'h0A, 2'd1, 1);
    applyStimulus(0, 1, 8'h0B, 0, 0);
    tick(); checkA("bp_full", 1, 8'h0A, 2'd2, 0);
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkA("bp_outA", 1, 8'h0A, 2'd2, 0);
    tick(); checkA("bp_outB", 1, 8'h0B, 2'd1, 1);
    tick(); checkA("bp_empty", 0, 8'h00, 2'd0, 1);

    // Flush with two entries held and an offered 0xC.
    applyStimulus(0, 1, 8'h05, 0, 0);
    tick();
    applyStimulus(0, 1, 8'h06, 0, 0);
    tick(); checkA("fl_full", 1, 8'h05, 2'd2, 0);
    applyStimulus(0, 1, 8'h0C, 0, 1);
    tick(); checkA("fl_after", 0, 8'h00, 2'd0, 1);
    applyStimulus(0, 0, 8'h00, 1, 0);
    tick(); checkA("fl_noC", 0, 8'h00, 2'd0, 1);

    // Flush with in_ready=1: the accepted 0xC is discarded.
    applyStimulus(0, 1, 8'h09, 0, 0);
    tick(); checkA("fl1_one", 1, 8'h09, 2'd1, 1);
    applyStimulus(0, 1, 8'h0C, 0, 1);
    checkOutput("fl1_ready_in_flush", 32'(a_in_ready), 32'd1);
    tick(); checkA("fl1_after", 0, 8'h00, 2'd0, 1);
    applyStimulus(0, 0, 8'h00, 1, 0);
    tick(); checkA("fl1_noC", 0, 8'h00, 2'd0, 1);

    // Stall counter saturation at CNT_W=2.
    rst = 1'b1; tick(); rst = 1'b0;
    applyStimulus(0, 1, 8'h04, 0, 0);
    tick(); checkOutput("stall0", 32'(a_stall), 32'd0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    tick(); checkOutput("stall1", 32'(a_stall), 32'd1);
    tick(); checkOutput("stall2", 32'(a_stall), 32'd2);
    tick(); checkOutput("stall3", 32'(a_stall), 32'd3);
    tick(); checkOutput("stall4_sat", 32'(a_stall), 32'd3);
    tick(); checkOutput("stall5_sat", 32'(a_stall), 32'd3);
    applyStimulus(0, 0, 8'h00, 0, 1);
    tick(); checkOutput("stall_flush", 32'(a_stall), 32'd3);
    checkA("stall_flush_state", 0, 8'h00, 2'd0, 1);
    applyStimulus(0, 0, 8'h00, 0, 0);
    tick(); checkOutput("stall_hold", 32'(a_stall), 32'd3);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checkOutput("stall_rst", 32'(a_stall), 32'd0);

    // Reset mid-operation with two entries held.
    applyStimulus(0, 1, 8'h11, 0, 0);
    tick();
    applyStimulus(0, 1, 8'h22, 0, 0);
    tick(); checkA("rst_full", 1, 8'h11, 2'd2, 0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checkA("rst_after", 0, 8'h00, 2'd0, 1);
    checkOutput("rst_after.stall", 32'(a_stall), 32'd0);

    // SKID=0: combinational in_ready and replace-on-transfer.
    applyStimulus(1, 1, 8'h03, 0, 0);
    tick(); checkB("b_load", 1, 8'h03, 2'd1, 0);
    applyStimulus(1, 1, 8'h08, 0, 0);
    tick(); checkB("b_hold", 1, 8'h03, 2'd1, 0);
    checkOutput("b_stall1", 32'(b_stall), 32'd1);
    applyStimulus(1, 1, 8'h07, 1, 0);
    checkOutput("b_ready_comb", 32'(b_in_ready), 32'd1);
    tick(); checkB("b_replace", 1, 8'h07, 2'd1, 1);
    applyStimulus(1, 0, 8'h00, 1, 0);
    tick(); checkB("b_empty", 0, 8'h00, 2'd0, 1);
    checkOutput("b_stall_end", 32'(b_stall), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameters (name, default, meaning) SHALL be, one per line:
  DATA_W  128  payload width in bits, >=1
  SKID    1    1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
  CNT_W   16   stall-counter width, >=1
REQ-002 Ports (name, direction, width, meaning) SHALL be, one per line:
  clk        in   1        single clock, rising edge
  rst        in   1        synchronous, active-high reset
  flush      in   1        kill all held entries, as the stage flush does
  in_valid   in   1        upstream entry valid
  in_ready   out  1        stage can accept an entry
  in_data    in   DATA_W   upstream payload
  out_valid  out  1        downstream entry valid
  out_ready  in   1        downstream accepts
  out_data   out  DATA_W   downstream payload
  occupancy  out  2        entries held, 0..2
  stall_cnt  out  CNT_W    cycles with out_valid=1 and out_ready=0

Function
REQ-003 Input transfer SHALL occur on an edge where in_valid=1 and in_ready=1; output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-004 Latency in_data to out_data SHALL be one cycle when the stage is empty.
REQ-005 Entries SHALL leave in arrival order; no entry is duplicated or dropped, except by flush.
REQ-006 SKID=1: in_ready SHALL equal NOT skid_valid, driven from a flop with no combinational path from out_ready.
REQ-007 SKID=1: an input transfer while the main entry is valid and no output transfer occurs SHALL load the skid entry.
REQ-008 SKID=1: on an output transfer with the skid entry valid, the skid entry SHALL move to the main entry; a simultaneous input transfer is impossible, because in_ready=0.
REQ-009 SKID=1: on an output transfer with the skid entry empty plus an input transfer, the main entry SHALL load in_data.
REQ-010 SKID=0: in_ready SHALL equal (NOT out_valid) OR out_ready; occupancy SHALL never exceed 1.
REQ-011 occupancy SHALL equal out_valid + skid_valid; the skid entry SHALL never be valid while the main entry is empty.
REQ-012 flush=1 SHALL clear both valids and zero both payloads at the next edge, override any simultaneous input or output transfer, and discard the input entry.
REQ-013 in_ready SHALL be unaffected by flush in the flush cycle; the upstream sees a transfer, but the entry is discarded.
REQ-014 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-015 While out_valid=0, out_data SHALL be zero.

Reset
REQ-016 rst=1 at an edge SHALL set out_valid=0, skid_valid=0, both payloads=0, occupancy=0 and stall_cnt=0, with priority over flush and all transfers.
REQ-017 After reset, in_ready SHALL be 1 from the first cycle.
REQ-018 Reset asserted mid-operation SHALL discard all held entries with no partial output.

Structure
REQ-019 The shared CPU package SHALL hold the skid-state enum (EMPTY, ONE, TWO) and the default DATA_W constant.
REQ-020 Control SHALL be a 3-state machine EMPTY/ONE/TWO; SKID=0 SHALL restrict it to EMPTY/ONE.
REQ-021 The design SHALL use one sub-module, pipe_data_reg: a DATA_W register with load, clear and synchronous reset, instantiated once for the main entry and once for the skid entry.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - SKID=1, out_ready=1, stream 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later; in_ready stays 1; occupancy 1.
  - SKID=1, send 0xA, then out_ready=0 and send 0xB -> occupancy=2, in_ready=0; raise out_ready -> 0xA then 0xB; in_ready returns to 1 after 0xA leaves.
  - Two entries held, flush=1 with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=0, occupancy=0; 0xC never appears.
  - out_valid=1 with out_ready=0 for 5 cycles, CNT_W=2 -> stall_cnt 1,2,3,3,3; flush leaves it 3; rst clears it to 0.
  - SKID=0, out_valid=1, out_ready=0 -> in_ready=0 combinationally; out_ready=1 with in_valid=1, in_data=0x7 -> 0x7 replaces the main entry next cycle.
  - rst=1 with two entries held and flush=0 -> all outputs are zero next cycle and in_ready=1.
